serial_tx: RTL and testbench
============================

SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 4, the number of clk cycles per serial bit; legal range 1..65535.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on posedge clk.
REQ-003 The block SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-004 The block SHALL have port tx_valid, input, 1, upstream asserts when tx_data holds a byte to send.
REQ-005 The block SHALL have port tx_data, input, 8, the byte to transmit; sampled only on acceptance.
REQ-006 The block SHALL have port tx_ready, output, 1, high when the block can accept a byte this cycle.
REQ-007 The block SHALL have port tx_out, output, 1, the serial line; idles high.
REQ-008 The block SHALL have port busy, output, 1, high while a frame is in progress.

Function
REQ-009 The block SHALL implement states IDLE, START, DATA and STOP.
REQ-010 Acceptance SHALL occur on any posedge where tx_valid=1 and tx_ready=1.
REQ-011 tx_ready SHALL equal 1 only in IDLE, and SHALL NOT depend combinationally on tx_valid.
REQ-012 On acceptance, tx_data SHALL be latched into an internal 8-bit shift register; later changes to tx_data SHALL NOT affect the frame.
REQ-013 IDLE->START SHALL occur on acceptance; tx_out SHALL drive 0 from the following cycle, so latency from acceptance edge to start bit is 1 cycle.
REQ-014 Each of START, each DATA bit and STOP SHALL hold tx_out for exactly CLKS_PER_BIT cycles, timed by a divider counter of width clog2(CLKS_PER_BIT)+1 that reloads at each bit boundary.
REQ-015 DATA SHALL send 8 bits LSB first, tracked by a 3-bit bit index that advances 0..7 with no wrap-around beyond 7; STOP SHALL be entered after bit 7.
REQ-016 STOP SHALL drive tx_out=1; on the last STOP cycle the state SHALL return to IDLE, so one frame occupies exactly 10*CLKS_PER_BIT cycles of busy=1.
REQ-017 Back-to-back transmission: tx_ready SHALL be 1 in the first IDLE cycle after STOP; a held tx_valid SHALL be accepted there, adding no gap beyond that one IDLE cycle of tx_out=1.
REQ-018 busy SHALL be 1 in START, DATA and STOP and 0 in IDLE.
REQ-019 tx_valid while not ready SHALL be ignored; the byte is not lost upstream because upstream holds it until acceptance.
REQ-020 With CLKS_PER_BIT=1, each bit SHALL last exactly one cycle and the frame SHALL last 10 cycles.
REQ-021 tx_out SHALL be driven from a register, with no combinational path from inputs.

Reset
REQ-022 When rst=1 at a posedge, the block SHALL enter IDLE with tx_out=1, tx_ready=1, busy=0, divider=0, bit index=0 and shift register=8'h00.
REQ-023 Reset SHALL have priority over acceptance in the same cycle; that byte is not accepted.
REQ-024 Reset mid-frame SHALL abort the frame, and tx_out SHALL be 1 from the cycle after the reset edge, with no partial stop bit.
REQ-025 No output SHALL be X after the first reset edge.

Verification
REQ-026 With CLKS_PER_BIT=4, send 8'h3E -> tx_out bits 0 | 0,1,1,1,1,1,0,0 | 1, each held 4 cycles; busy=1 for 40 cycles; tx_ready=0 throughout.
REQ-027 Hold tx_valid with 8'hA5 then 8'h5A -> the second byte is accepted in the first IDLE cycle after the first STOP, and the line shows a 1-cycle idle high between frames.
REQ-028 Change tx_data from 8'h3E to 8'hFF one cycle after acceptance -> the transmitted byte remains 8'h3E.
REQ-029 Assert rst during DATA bit 3 of 8'h00 -> next cycle tx_out=1, busy=0, tx_ready=1, and a new byte 8'h81 then sends correctly.
REQ-030 rst=1 and tx_valid=1 in the same cycle -> no acceptance, tx_out stays 1, and acceptance occurs on the first cycle after rst falls.
REQ-031 With CLKS_PER_BIT=1, send 8'hFF -> tx_out sequence 0,1,1,1,1,1,1,1,1,1 and busy=1 for exactly 10 cycles.

Source files
------------

// File: rtl/serial_tx.sv
// serial_tx: 8N1 serial transmitter with a valid/ready byte input.
// Frame = start bit (0), 8 data bits LSB first, stop bit (1); each bit is
// held for CLKS_PER_BIT clock cycles. tx_out is registered.
module serial_tx #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_out,
  output logic       busy
);

  localparam int unsigned DIV_W = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t           r_state,  w_state_nxt;
  logic [DIV_W-1:0] r_div,    w_div_nxt;
  logic [2:0]       r_bit,    w_bit_nxt;
  logic [7:0]       r_shift,  w_shift_nxt;
  logic             r_tx_out, w_tx_out_nxt;
  logic             w_bit_end;

  assign w_bit_end = (r_div == DIV_LAST);

  // State and datapath registers; reset forces an idle, high line.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_div    <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_tx_out <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_div    <= w_div_nxt;
      r_bit    <= w_bit_nxt;
      r_shift  <= w_shift_nxt;
      r_tx_out <= w_tx_out_nxt;
    end
  end

  // Next-state logic; the value of each bit is computed one cycle ahead so
  // the line comes straight from a flop.
  always_comb begin
    w_state_nxt  = r_state;
    w_div_nxt    = r_div;
    w_bit_nxt    = r_bit;
    w_shift_nxt  = r_shift;
    w_tx_out_nxt = r_tx_out;
    case (r_state)
      IDLE: begin
        w_tx_out_nxt = 1'b1;
        if (tx_valid) begin
          w_state_nxt  = START;
          w_shift_nxt  = tx_data;
          w_div_nxt    = '0;
          w_bit_nxt    = '0;
          w_tx_out_nxt = 1'b0;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_state_nxt  = DATA;
          w_div_nxt    = '0;
          w_tx_out_nxt = r_shift[0];
        end else begin
          w_div_nxt = r_div + 1'b1;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_div_nxt = '0;
          if (r_bit == 3'd7) begin
            w_state_nxt  = STOP;
            w_tx_out_nxt = 1'b1;
          end else begin
            // Shift register's bit 0 is on the line; bit 1 goes out next.
            w_bit_nxt    = r_bit + 3'd1;
            w_shift_nxt  = {1'b0, r_shift[7:1]};
            w_tx_out_nxt = r_shift[1];
          end
        end else begin
          w_div_nxt = r_div + 1'b1;
        end
      end
      STOP: begin
        if (w_bit_end) begin
          w_state_nxt = IDLE;
          w_div_nxt   = '0;
          w_bit_nxt   = '0;
        end else begin
          w_div_nxt = r_div + 1'b1;
        end
      end
      default: begin
        w_state_nxt  = IDLE;
        w_tx_out_nxt = 1'b1;
      end
    endcase
  end

  assign tx_ready = (r_state == IDLE);
  assign busy     = (r_state != IDLE);
  assign tx_out   = r_tx_out;

endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: two serial_tx instances (CLKS_PER_BIT=4 and =1) checked
// every cycle against a frame-level reference model, plus directed frames.
module tb_serial_tx;

  logic       clk = 1'b0;
  logic [1:0] rst;
  logic [1:0] valid;
  logic [7:0] data [2];
  logic [1:0] ready;
  logic [1:0] txo;
  logic [1:0] busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_tx #(.CLKS_PER_BIT(4)) u_dut4 (
    .clk      (clk),
    .rst      (rst[0]),
    .tx_valid (valid[0]),
    .tx_data  (data[0]),
    .tx_ready (ready[0]),
    .tx_out   (txo[0]),
    .busy     (busy[0])
  );

  serial_tx #(.CLKS_PER_BIT(1)) u_dut1 (
    .clk      (clk),
    .rst      (rst[1]),
    .tx_valid (valid[1]),
    .tx_data  (data[1]),
    .tx_ready (ready[1]),
    .tx_out   (txo[1]),
    .busy     (busy[1])
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int cpb(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  // Reference model: a frame is a 10-bit vector; m_cnt counts the busy
  // cycles remaining (0 means idle and ready).
  int         m_cnt   [2] = '{0, 0};
  logic [9:0] m_frame [2] = '{10'h3FF, 10'h3FF};
  bit         m_en    [2] = '{1'b0, 1'b0};

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst[k]) begin
        m_cnt[k] = 0;
        m_en[k]  = 1'b1;
      end else if (m_cnt[k] == 0 && valid[k]) begin
        m_frame[k] = {1'b1, data[k], 1'b0};
        m_cnt[k]   = 10 * cpb(k);
      end else if (m_cnt[k] > 0) begin
        m_cnt[k] = m_cnt[k] - 1;
      end
    end
  end

  function automatic logic exp_out(input int k);
    if (m_cnt[k] == 0) return 1'b1;
    return m_frame[k][(10 * cpb(k) - m_cnt[k]) / cpb(k)];
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (m_en[k]) begin
        chk($sformatf("ready%0d", k), 64'(ready[k]), 64'(m_cnt[k] == 0));
        chk($sformatf("busy%0d", k),  64'(busy[k]),  64'(m_cnt[k] != 0));
        chk($sformatf("txout%0d", k), 64'(txo[k]),   64'(exp_out(k)));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Offer one byte, drop valid after the acceptance edge (optionally
  // replacing tx_data), and record tx_out during every busy cycle.
  task automatic send_collect(input int k, input logic [7:0] b, input int n,
                              input logic [7:0] after, output int nb,
                              output logic [39:0] s);
    nb = 0;
    s  = '0;
    valid[k] = 1'b1;
    data[k]  = b;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (busy[k] === 1'b1) begin
        if (nb < 40) s[nb] = txo[k];
        nb++;
      end
      if (i == 0) begin
        valid[k] = 1'b0;
        data[k]  = after;
      end
    end
  endtask

  function automatic logic [39:0] exp_wave(input logic [7:0] b, input int c);
    logic [9:0]  f;
    logic [39:0] w;
    f = {1'b1, b, 1'b0};
    w = '0;
    for (int j = 0; j < 10 * c; j++) w[j] = f[j / c];
    return w;
  endfunction

  initial begin
    int          nb;
    logic [39:0] s;
    rst     = 2'b11;
    valid   = 2'b00;
    data[0] = 8'h00;
    data[1] = 8'h00;
    step(2);
    chk("rst_ready", 64'(ready), 64'(2'b11));
    chk("rst_txout", 64'(txo),   64'(2'b11));
    chk("rst_busy",  64'(busy),  64'(2'b00));
    rst = 2'b00;
    step(1);

    // 0x3E at 4 clocks/bit; tx_data switches to 0xFF right after acceptance.
    send_collect(0, 8'h3E, 45, 8'hFF, nb, s);
    chk("3E_busylen", 64'(nb), 64'd40);
    chk("3E_wave", 64'(s), 64'(exp_wave(8'h3E, 4)));

    // 0xFF at 1 clock/bit.
    send_collect(1, 8'hFF, 14, 8'h00, nb, s);
    chk("FF1_busylen", 64'(nb), 64'd10);
    chk("FF1_wave", 64'(s[9:0]), 64'(10'b11_1111_1110));

    // Back-to-back: hold valid with A5 then 5A.
    valid[0] = 1'b1;
    data[0]  = 8'hA5;
    step(1);
    data[0] = 8'h5A;
    step(40);
    chk("b2b_idle_ready", 64'(ready[0]), 64'd1);
    chk("b2b_idle_line",  64'(txo[0]),   64'd1);
    step(1);
    chk("b2b_second_busy", 64'(busy[0]), 64'd1);
    valid[0] = 1'b0;
    step(45);

    // Reset during data bit 3 of 0x00, then 0x81.
    valid[0] = 1'b1;
    data[0]  = 8'h00;
    step(1);
    valid[0] = 1'b0;
    step(17);
    rst[0] = 1'b1;
    step(1);
    rst[0] = 1'b0;
    chk("abort_txout", 64'(txo[0]),   64'd1);
    chk("abort_busy",  64'(busy[0]),  64'd0);
    chk("abort_ready", 64'(ready[0]), 64'd1);
    send_collect(0, 8'h81, 45, 8'h00, nb, s);
    chk("81_busylen", 64'(nb), 64'd40);
    chk("81_wave", 64'(s), 64'(exp_wave(8'h81, 4)));

    // Reset and valid together: no acceptance until rst falls.
    rst[0]   = 1'b1;
    valid[0] = 1'b1;
    data[0]  = 8'hC3;
    step(2);
    chk("rstv_busy", 64'(busy[0]), 64'd0);
    chk("rstv_line", 64'(txo[0]),  64'd1);
    rst[0] = 1'b0;
    step(1);
    chk("rstv_accept", 64'(busy[0]), 64'd1);
    valid[0] = 1'b0;
    step(45);

    // Random traffic on both instances.
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < 2; k++) begin
        rst[k]   = ($urandom_range(0, 99) < 2);
        valid[k] = ($urandom_range(0, 2) != 0);
        data[k]  = 8'($urandom);
      end
      step(1);
    end
    rst   = 2'b00;
    valid = 2'b00;
    step(50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
